// File: rtl/rst_seq_ctrl.sv
// =============================================================================
// Module      : rst_seq_ctrl
// Description : Reset sequencer. It synchronises release of the global async
//               reset, then releases N_DOM domain resets in index order with a
//               programmable gap. It also re-runs the release from any domain
//               that software requests. Optional macro RST_SEQ_CNT_EN adds a
//               saturating restart counter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rst_seq_ctrl #(
    parameter int N_DOM    = 4,
    parameter int DLY_W    = 8,
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [DLY_W-1:0] cfg_gap,
    input  logic [N_DOM-1:0] sw_req,
    output logic [N_DOM-1:0] rst_out,
    output logic             busy,
    output logic             done
`ifdef RST_SEQ_CNT_EN
    ,
    output logic [7:0]       restart_cnt
`endif
);

    localparam int IDX_W = $clog2(N_DOM);

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [SYNC_STG-1:0] r_sync;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [DLY_W-1:0]    r_cnt;
    logic [DLY_W-1:0]    w_cnt_nxt;
    logic [DLY_W-1:0]    w_eff_gap;
    logic [N_DOM-1:0]    w_rst_nxt;
    logic [N_DOM-1:0]    w_req_mask;
    logic [IDX_W:0]      w_req_idx;
    logic [IDX_W:0]      w_first_on;
    logic                w_sync_rel;
    logic                w_accept;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], 1'b1};
        end
    end

    // The chain fills as a thermometer code, so the FSM leaves SYNC on the
    // same edge that loads a 1 into the last stage.
    assign w_sync_rel = r_sync[SYNC_STG-2] | r_sync[SYNC_STG-1];
    assign w_eff_gap  = (cfg_gap == '0) ? DLY_W'(1) : cfg_gap;

    // Lowest requested domain and lowest domain still held in reset.
    // If there is no match, the result is N_DOM.
    always_comb begin
        w_req_idx  = (IDX_W+1)'(N_DOM);
        w_first_on = (IDX_W+1)'(N_DOM);
        w_req_mask = '0;
        for (int i = N_DOM - 1; i >= 0; i--) begin
            if (sw_req[i]) begin
                w_req_idx = (IDX_W+1)'(i);
            end
            if (rst_out[i]) begin
                w_first_on = (IDX_W+1)'(i);
            end
        end
        for (int i = 0; i < N_DOM; i++) begin
            w_req_mask[i] = ((IDX_W+1)'(i) >= w_req_idx);
        end
    end

    assign w_accept = (r_state != S_SYNC) && (w_req_idx < w_first_on);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_SYNC;
            r_idx   <= '0;
            r_cnt   <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            rst_out <= w_rst_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            w_state_nxt = S_GAP;
            w_idx_nxt   = w_req_idx[IDX_W-1:0];
            w_cnt_nxt   = w_eff_gap;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_sync_rel) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = w_eff_gap;
                    end
                end
                S_GAP: begin
                    if (r_cnt <= DLY_W'(1)) begin
                        w_state_nxt = S_REL;
                    end else begin
                        w_cnt_nxt = r_cnt - DLY_W'(1);
                    end
                end
                S_REL: begin
                    if (r_idx == IDX_W'(N_DOM - 1)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_cnt_nxt   = w_eff_gap;
                    end
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // An accepted request takes priority over a release in the same cycle.
    always_comb begin
        w_rst_nxt = rst_out;
        if (w_accept) begin
            w_rst_nxt = rst_out | w_req_mask;
        end else if (r_state == S_REL) begin
            w_rst_nxt[r_idx] = 1'b0;
        end
        w_busy_nxt = (w_state_nxt != S_RUN);
        w_done_nxt = (w_state_nxt == S_RUN);
    end

`ifdef RST_SEQ_CNT_EN
    logic [7:0] r_restart;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_restart <= '0;
        end else if (w_accept && (r_restart != 8'hFF)) begin
            r_restart <= r_restart + 8'd1;
        end
    end

    assign restart_cnt = r_restart;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// =============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Self-checking bench for rst_seq_ctrl. It uses per-cycle vector
//               tables with a scoreboard queue.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] cfg_gap = 8'd3;
    logic [3:0] sw_req = 4'd0;
    logic [3:0] rst_out;
    logic       busy;
    logic       done;
`ifdef RST_SEQ_CNT_EN
    logic [7:0] restart_cnt;
`endif

    always #5 clk = ~clk;

    rst_seq_ctrl #(.N_DOM(4), .DLY_W(8), .SYNC_STG(2)) u_dut (
        .clk     (clk),
        .arst    (arst),
        .cfg_gap (cfg_gap),
        .sw_req  (sw_req),
        .rst_out (rst_out),
        .busy    (busy),
        .done    (done)
`ifdef RST_SEQ_CNT_EN
        ,
        .restart_cnt (restart_cnt)
`endif
    );

    typedef struct {
        logic [3:0] req;
        int         n;
        logic [3:0] rst;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] req, input int n, input logic [3:0] r,
                                input logic b, input logic d);
        vec_t v;
        v.req = req; v.n = n; v.rst = r; v.busy = b; v.done = d;
        tbl.push_back(v);
    endfunction

    // One clock: drive the request, queue the expected outputs, then compare at the next negedge.
    task automatic step(input logic [3:0] req, input logic [5:0] e, input string name);
        logic [5:0] x;
        sw_req = req;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        check(name, {26'd0, rst_out, busy, done}, {26'd0, x});
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                step(tbl[i].req, {tbl[i].rst, tbl[i].busy, tbl[i].done},
                     $sformatf("%s[%0d.%0d]", tag, i, c));
            end
        end
        tbl.delete();
    endtask

    // Released bits must drop one at a time, lowest index first.
    logic [3:0] mon_prev = 4'hF;
    logic [3:0] mon_fell;
    always @(negedge clk) begin
        mon_fell = mon_prev & ~rst_out;
        if (mon_fell != 4'd0 && !arst) begin
            n_tests++;
            if ($countones(mon_fell) != 1 || (rst_out & (mon_fell - 4'd1)) != 4'd0) begin
                n_fail++;
                $display("FAIL release_order: got %b after %b", rst_out, mon_prev);
            end
        end
        mon_prev = rst_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        check("reset_state", {28'd0, rst_out}, 32'hF);
        check("reset_flags", {30'd0, busy, done}, 32'd2);
`ifdef RST_SEQ_CNT_EN
        check("reset_cnt", {24'd0, restart_cnt}, 32'd0);
`endif
        // Power-on release with gap 3, then a software restart of domain 2 from RUN
        arst = 1'b0;
        add(4'b0000, 5, 4'b1111, 1, 0);
        add(4'b0000, 4, 4'b1110, 1, 0);
        add(4'b0000, 4, 4'b1100, 1, 0);
        add(4'b0000, 4, 4'b1000, 1, 0);
        add(4'b0000, 3, 4'b0000, 0, 1);
        add(4'b0100, 1, 4'b1100, 1, 0);
        add(4'b0000, 3, 4'b1100, 1, 0);
        add(4'b0000, 4, 4'b1000, 1, 0);
        add(4'b0000, 2, 4'b0000, 0, 1);
        run_tbl("pwr");
`ifdef RST_SEQ_CNT_EN
        check("cnt_after_pwr", {24'd0, restart_cnt}, 32'd1);
`endif
        // Held request on domain 1: released once, then re-asserted on the next cycle
        add(4'b0010, 4, 4'b1110, 1, 0);
        add(4'b0010, 1, 4'b1100, 1, 0);
        add(4'b0010, 1, 4'b1110, 1, 0);
        add(4'b0000, 3, 4'b1110, 1, 0);
        add(4'b0000, 4, 4'b1100, 1, 0);
        add(4'b0000, 4, 4'b1000, 1, 0);
        add(4'b0000, 1, 4'b0000, 0, 1);
        run_tbl("hold");
`ifdef RST_SEQ_CNT_EN
        check("cnt_after_hold", {24'd0, restart_cnt}, 32'd3);
`endif
        // Mid-sequence: a request on an already-reset domain is ignored; 0110 restarts from domain 1
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        add(4'b0000, 5, 4'b1111, 1, 0);
        add(4'b0000, 4, 4'b1110, 1, 0);
        add(4'b0000, 4, 4'b1100, 1, 0);
        add(4'b0000, 1, 4'b1000, 1, 0);
        add(4'b1000, 1, 4'b1000, 1, 0);
        add(4'b0110, 1, 4'b1110, 1, 0);
        add(4'b0000, 3, 4'b1110, 1, 0);
        add(4'b0000, 4, 4'b1100, 1, 0);
        add(4'b0000, 4, 4'b1000, 1, 0);
        add(4'b0000, 1, 4'b0000, 0, 1);
        run_tbl("mid");
`ifdef RST_SEQ_CNT_EN
        check("cnt_after_mid", {24'd0, restart_cnt}, 32'd1);
`endif
        // Async reset while rst_out=1100 must take effect without a clock edge
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        add(4'b0000, 5, 4'b1111, 1, 0);
        add(4'b0000, 4, 4'b1110, 1, 0);
        add(4'b0000, 2, 4'b1100, 1, 0);
        run_tbl("pre_arst");
        arst = 1'b1;
        #1;
        check("arst_async_rst", {28'd0, rst_out}, 32'hF);
        check("arst_async_flags", {30'd0, busy, done}, 32'd2);
`ifdef RST_SEQ_CNT_EN
        check("arst_async_cnt", {24'd0, restart_cnt}, 32'd0);
`endif
        @(negedge clk);
        // A gap of zero is treated as 1, so releases are 2 cycles apart
        cfg_gap = 8'd0;
        arst = 1'b0;
        add(4'b0000, 3, 4'b1111, 1, 0);
        add(4'b0000, 2, 4'b1110, 1, 0);
        add(4'b0000, 2, 4'b1100, 1, 0);
        add(4'b0000, 2, 4'b1000, 1, 0);
        add(4'b0000, 2, 4'b0000, 0, 1);
        run_tbl("gap0");
        // Hold a request on domain 0 long enough to take well over 255 restarts
        sw_req = 4'b0001;
        repeat (1000) @(negedge clk);
        sw_req = 4'b0000;
`ifdef RST_SEQ_CNT_EN
        check("cnt_saturate", {24'd0, restart_cnt}, 32'd255);
`endif
        waited = 0;
        while (!done && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("sat_done", {28'd0, rst_out, 3'd0, done} >> 0, {28'd0, 4'b0000, 3'd0, 1'b1});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
